pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Parametrised next-generation program counter for the fetch stage. Holds the current fetch address and selects each cycle between hold, sequential increment, branch/jump redirect, trap vector, call and return. Calls and returns are handled by an internal circular return-address stack (RAS). The fetch stage consumes `pc`; execute and trap logic drive the control inputs.

## Interface
Parameters:
- `XLEN`, 32, address width in bits.
- `RESET_VECTOR`, 0, value of `pc` after reset.
- `TRAP_VECTOR`, 32'h0000_0100, value loaded when `trap` is asserted.
- `PC_INC`, 4, sequential increment, also the alignment granule. Must be a power of two.
- `RAS_DEPTH`, 4, number of RAS entries. Must be a power of two, ≥2.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `stall`  in  1  hold `pc` and RAS unchanged.
- `trap`  in  1  load `TRAP_VECTOR`.
- `redirect_valid`  in  1  load `redirect_pc`.
- `redirect_pc`  in  XLEN  branch/jump target.
- `call`  in  1  push return address and load `call_target`.
- `call_target`  in  XLEN  call destination.
- `ret`  in  1  pop the RAS and load the popped address.
- `pc`  out  XLEN  current fetch address, registered.
- `pc_valid`  out  1  low while in reset, high from the first cycle after reset is deasserted.
- `ras_empty`  out  1  RAS count == 0.
- `ras_full`  out  1  RAS count == `RAS_DEPTH`.
- `ras_underflow`  out  1  one-cycle pulse: a `ret` was accepted while the RAS was empty.

## Operation
- **Reset:** `pc`=`RESET_VECTOR`, `pc_valid`=0, RAS count=0, pointer=0, `ras_empty`=1, `ras_full`=0, `ras_underflow`=0.
- **Priority per cycle (highest first):** reset > trap > redirect_valid > stall > call/ret > sequential.
  - **trap:** `pc` <= `TRAP_VECTOR`. RAS untouched. Overrides `stall`.
  - **redirect:** `pc` <= `redirect_pc` with the log2(`PC_INC`) LSBs forced to 0. RAS untouched. Overrides `stall`.
  - **stall:** `pc` and RAS hold. `call`/`ret` are ignored, not queued.
  - **call only:** push `pc + PC_INC` (modulo 2^XLEN), then `pc` <= `call_target` (aligned).
  - **ret only, RAS non-empty:** `pc` <= top entry; count decrements.
  - **ret only, RAS empty:** `pc` <= `pc + PC_INC`; `ras_underflow` pulses; count stays 0.
  - **call and ret together:** overwrite the top entry with `pc + PC_INC` (count unchanged; if empty, behaves as push). `pc` <= `call_target`.
  - **sequential (no control asserted):** `pc` <= `pc + PC_INC`, wrapping at 2^XLEN.
- **RAS push when full:** overwrites the oldest entry (circular). Count saturates at `RAS_DEPTH`; `ras_full` stays 1.
- **RAS pointer:** log2(`RAS_DEPTH`) bits, wraps modulo `RAS_DEPTH`. Count is log2(`RAS_DEPTH`)+1 bits.
- **Lower-priority inputs:** a `call`/`ret` in a cycle won by trap or redirect has no RAS effect.

## Timing
- All outputs are registered.
- Inputs sampled at edge N take effect in `pc`, flags and `ras_underflow` after edge N, i.e. one cycle of latency.
- Next-PC selection and RAS read are combinational within the cycle.
- `ras_underflow` is high for exactly one cycle per underflowing `ret`.
- Reset asserted mid-sequence: takes effect at the next edge regardless of other inputs. RAS contents become don't-care; count=0.
- `pc_valid` rises on the first edge where `reset` is sampled low.

## Structure
- **Package `pc_pkg`:** enum `pc_sel_e` {PC_SEQ, PC_HOLD, PC_REDIRECT, PC_TRAP, PC_CALL, PC_RET, PC_RET_UF}, plus a function returning `pc_sel_e` from the control inputs. The function encodes the priority above.
- **Sub-module `return_stack`:** parameters `XLEN`, `DEPTH`. Ports push, pop, push_data, top, empty, full. Owns the circular storage, pointer, count and the replace-on-push+pop case.
- **`pc_sequencer`:** holds the `pc` register, the next-PC mux, alignment and the underflow pulse.

## Test plan
- Reset then 3 idle cycles -> `pc` = 0, 4, 8, 12. `pc_valid` 0 during reset, 1 after.
- At `pc`=0x10, `redirect_pc`=0x203 together with `stall`=1 -> next `pc`=0x200. Following cycle with `stall`=1 -> `pc` holds 0x200.
- Five calls from `pc` 0x0, 0x40, 0x80, 0xC0, 0x100 (each to `pc`+0x40) with `RAS_DEPTH`=4 -> `ras_full`=1. Four `ret`s yield 0x104, 0xC4, 0x84, 0x44, then `ras_empty`=1.
- `ret` on an empty RAS at `pc`=0x30 -> `pc`=0x34, `ras_underflow` high for exactly 1 cycle.
- Same cycle `trap`=1, `redirect_valid`=1, `call`=1 -> `pc`=0x100, RAS count unchanged. Also: `call`+`ret` together at `pc`=0x50 with target 0x300 -> `pc`=0x300, top entry=0x54, count unchanged.
- `pc`=0xFFFF_FFFC with no control asserted -> `pc` wraps to 0x0. Reset asserted mid-call sequence -> `pc`=`RESET_VECTOR`, `ras_empty`=1 next cycle.

Source files
------------

// File: rtl/pc_pkg.sv
// pc_pkg: next-PC source selection shared by the sequencer
package pc_pkg;
  typedef enum logic [2:0] {PC_SEQ, PC_HOLD, PC_REDIRECT, PC_TRAP, PC_CALL, PC_RET, PC_RET_UF} pc_sel_e;
  // Priority: trap > redirect > stall > call (alone or with ret) > ret > sequential
  function automatic pc_sel_e pc_select(input logic trap, input logic redirect_valid, input logic stall,
                                        input logic call, input logic ret, input logic ras_empty);
    return trap ? PC_TRAP : redirect_valid ? PC_REDIRECT : stall ? PC_HOLD : call ? PC_CALL :
           ret ? (ras_empty ? PC_RET_UF : PC_RET) : PC_SEQ;
  endfunction
endpackage

// File: rtl/pc_sequencer_return_stack.sv
// return_stack: circular return-address stack, oldest entry overwritten when full
module return_stack #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            push,
  input  logic            pop,
  input  logic [XLEN-1:0] push_data,
  output logic [XLEN-1:0] top,
  output logic            empty,
  output logic            full
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic [XLEN-1:0] r_mem [DEPTH];
  logic [PW-1:0]   r_ptr;
  logic [CW-1:0]   r_cnt;
  logic [PW-1:0]   w_top_idx;
  logic            w_replace;
  logic            w_push_new;
  logic            w_pop_only;
  assign w_top_idx  = r_ptr - PW'(1);
  assign top        = r_mem[w_top_idx];
  assign empty      = r_cnt == '0;
  assign full       = r_cnt == CW'(DEPTH);
  assign w_replace  = push & pop & ~empty;
  assign w_push_new = push & ~w_replace;
  assign w_pop_only = pop & ~push & ~empty;
  // Storage: push+pop rewrites the top in place, plain push writes the next free slot
  always_ff @(posedge clk) begin
    if (w_replace) r_mem[w_top_idx] <= push_data;
    else if (w_push_new) r_mem[r_ptr] <= push_data;
  end
  // Pointer wraps modulo DEPTH; count saturates at DEPTH so a full push drops the oldest
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr <= '0;
      r_cnt <= '0;
    end else if (w_push_new) begin
      r_ptr <= r_ptr + PW'(1);
      r_cnt <= full ? r_cnt : r_cnt + CW'(1);
    end else if (w_pop_only) begin
      r_ptr <= w_top_idx;
      r_cnt <= r_cnt - CW'(1);
    end
  end
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch program counter with redirect, trap, call/return via RAS
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int                XLEN         = 32,
  parameter logic [XLEN-1:0]   RESET_VECTOR = '0,
  parameter logic [XLEN-1:0]   TRAP_VECTOR  = XLEN'(32'h0000_0100),
  parameter int                PC_INC       = 4,
  parameter int                RAS_DEPTH    = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            trap,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            call,
  input  logic [XLEN-1:0] call_target,
  input  logic            ret,
  output logic [XLEN-1:0] pc,
  output logic            pc_valid,
  output logic            ras_empty,
  output logic            ras_full,
  output logic            ras_underflow
);
  localparam logic [XLEN-1:0] ALIGN_MASK = ~(XLEN'(PC_INC) - XLEN'(1));
  logic [XLEN-1:0] r_pc;
  logic            r_valid;
  logic            r_uf;
  logic [XLEN-1:0] w_seq;
  logic [XLEN-1:0] w_next;
  logic [XLEN-1:0] w_top;
  logic            w_push;
  logic            w_pop;
  pc_sel_e         w_sel;
  assign w_sel  = pc_select(trap, redirect_valid, stall, call, ret, ras_empty);
  assign w_seq  = r_pc + XLEN'(PC_INC);
  assign w_push = w_sel == PC_CALL;
  assign w_pop  = (w_sel == PC_RET) | (w_push & ret);
  return_stack #(.XLEN(XLEN), .DEPTH(RAS_DEPTH)) u_ras (
    .clk      (clk),
    .reset    (reset),
    .push     (w_push),
    .pop      (w_pop),
    .push_data(w_seq),
    .top      (w_top),
    .empty    (ras_empty),
    .full     (ras_full)
  );
  // Next-PC mux; external targets are aligned to the increment granule
  always_comb begin
    w_next = w_seq;
    case (w_sel)
      PC_HOLD:     w_next = r_pc;
      PC_TRAP:     w_next = TRAP_VECTOR;
      PC_REDIRECT: w_next = redirect_pc & ALIGN_MASK;
      PC_CALL:     w_next = call_target & ALIGN_MASK;
      PC_RET:      w_next = w_top;
      default:     w_next = w_seq;
    endcase
  end
  // PC, valid flag and one-cycle underflow pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc    <= RESET_VECTOR;
      r_valid <= 1'b0;
      r_uf    <= 1'b0;
    end else begin
      r_pc    <= w_next;
      r_valid <= 1'b1;
      r_uf    <= w_sel == PC_RET_UF;
    end
  end
  assign pc            = r_pc;
  assign pc_valid      = r_valid;
  assign ras_underflow = r_uf;
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed vectors with a queued scoreboard checked by a monitor
module tb_pc_sequencer;
  logic        clk = 0;
  logic        reset = 0, stall = 0, trap = 0, redirect_valid = 0, call = 0, ret = 0;
  logic [31:0] redirect_pc = 0, call_target = 0;
  logic [31:0] pc;
  logic        pc_valid, ras_empty, ras_full, ras_underflow;
  typedef struct {int due; string name; logic [35:0] v;} exp_t;
  exp_t q[$];
  int cyc = 0, checks = 0, errors = 0;
  pc_sequencer dut (
    .clk(clk), .reset(reset), .stall(stall), .trap(trap),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .call(call), .call_target(call_target), .ret(ret),
    .pc(pc), .pc_valid(pc_valid), .ras_empty(ras_empty), .ras_full(ras_full),
    .ras_underflow(ras_underflow)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  // Monitor: compare every expectation due in the cycle that just completed
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].due == cyc) begin
      automatic exp_t e = q.pop_front();
      automatic logic [35:0] act = {pc, pc_valid, ras_empty, ras_full, ras_underflow};
      checks++;
      if (act !== e.v) begin
        errors++;
        $display("FAIL %s: got pc=%h flags(valid,empty,full,uf)=%b, expected pc=%h flags=%b",
                 e.name, act[35:4], act[3:0], e.v[35:4], e.v[3:0]);
      end
    end
  end
  task automatic step(input string n, input logic rs, input logic st, input logic tr,
                      input logic rv, input logic [31:0] rp, input logic cl, input logic [31:0] ct,
                      input logic rt, input logic [31:0] ep, input logic [3:0] ef);
    @(posedge clk);
    #1;
    reset = rs; stall = st; trap = tr; redirect_valid = rv; redirect_pc = rp;
    call = cl; call_target = ct; ret = rt;
    q.push_back('{cyc + 1, n, {ep, ef}});
  endtask
  initial begin
    step("reset0", 1,0,0,0,0,0,0,0, 32'h0, 4'b0100);
    step("reset1", 1,0,0,0,0,0,0,0, 32'h0, 4'b0100);
    step("seq4",   0,0,0,0,0,0,0,0, 32'h4, 4'b1100);
    step("seq8",   0,0,0,0,0,0,0,0, 32'h8, 4'b1100);
    step("seq12",  0,0,0,0,0,0,0,0, 32'hC, 4'b1100);
    step("seq16",  0,0,0,0,0,0,0,0, 32'h10, 4'b1100);
    step("redir_over_stall", 0,1,0,1,32'h203,0,0,0, 32'h200, 4'b1100);
    step("stall_hold", 0,1,0,0,0,0,0,0, 32'h200, 4'b1100);
    step("redir0", 0,0,0,1,32'h0,0,0,0, 32'h0, 4'b1100);
    step("call1", 0,0,0,0,0,1,32'h40,0,  32'h40,  4'b1000);
    step("call2", 0,0,0,0,0,1,32'h80,0,  32'h80,  4'b1000);
    step("call3", 0,0,0,0,0,1,32'hC0,0,  32'hC0,  4'b1000);
    step("call4_full", 0,0,0,0,0,1,32'h100,0, 32'h100, 4'b1010);
    step("call5_wrap", 0,0,0,0,0,1,32'h140,0, 32'h140, 4'b1010);
    step("ret1", 0,0,0,0,0,0,0,1, 32'h104, 4'b1000);
    step("ret2", 0,0,0,0,0,0,0,1, 32'hC4,  4'b1000);
    step("ret3", 0,0,0,0,0,0,0,1, 32'h84,  4'b1000);
    step("ret4_empty", 0,0,0,0,0,0,0,1, 32'h44, 4'b1100);
    step("redir30", 0,0,0,1,32'h30,0,0,0, 32'h30, 4'b1100);
    step("ret_underflow", 0,0,0,0,0,0,0,1, 32'h34, 4'b1101);
    step("uf_one_cycle", 0,0,0,0,0,0,0,0, 32'h38, 4'b1100);
    step("stall_call_ignored", 0,1,0,0,0,1,32'h1000,0, 32'h38, 4'b1100);
    step("stall_ret_ignored", 0,1,0,0,0,0,0,1, 32'h38, 4'b1100);
    step("call_align", 0,0,0,0,0,1,32'h1002,0, 32'h1000, 4'b1000);
    step("trap_wins", 0,0,1,1,32'h500,1,32'h700,0, 32'h100, 4'b1000);
    step("redir50", 0,0,0,1,32'h50,0,0,0, 32'h50, 4'b1000);
    step("call_ret_replace", 0,0,0,0,0,1,32'h300,1, 32'h300, 4'b1000);
    step("ret_replaced_top", 0,0,0,0,0,0,0,1, 32'h54, 4'b1100);
    step("redir_beats_ret", 0,0,0,1,32'h60,0,0,1, 32'h60, 4'b1100);
    step("redir_top", 0,0,0,1,32'hFFFF_FFFC,0,0,0, 32'hFFFF_FFFC, 4'b1100);
    step("wrap0", 0,0,0,0,0,0,0,0, 32'h0, 4'b1100);
    step("call_pre_reset", 0,0,0,0,0,1,32'h80,0, 32'h80, 4'b1000);
    step("reset_mid_call", 1,0,0,0,0,1,32'h200,0, 32'h0, 4'b0100);
    step("post_reset_seq", 0,0,0,0,0,0,0,0, 32'h4, 4'b1100);
    step("post_reset_uf", 0,0,0,0,0,0,0,1, 32'h8, 4'b1101);
    step("post_reset_idle", 0,0,0,0,0,0,0,0, 32'hC, 4'b1100);
    @(posedge clk);
    #1;
    {reset, stall, trap, redirect_valid, call, ret} = '0;
    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    #1;
    if (q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending expectations, expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
